// File: rtl/addsub_seq.sv
// Byte-serial add/subtract/compare sequencer driving an external 8-bit datapath.
// Optional ADDSUB_SEQ_OPCHECK_EN: op=11 pulses err instead of running as CMP.
//
// Ports:
//   clk, rst                    single clock, synchronous active-high reset
//   start, op, len_m1           command (ADD=00, SUB=01, CMP=10), length-1 in bytes
//   in_a, in_b, in_valid/ready  operand bytes, least significant first
//   out_data, out_valid/ready   result byte stream (ADD/SUB only)
//   dp_a, dp_b, dp_sub_sel,
//   dp_csel, dp_addsub, dp_cmp_n datapath controls
//   dp_sum, dp_sign, dp_z       datapath results
//   busy, done, res_sign,
//   res_zero, err               status
module addsub_seq #(
    parameter int MAX_BYTES = 8,
    parameter int LEN_W     = $clog2(MAX_BYTES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [LEN_W-1:0] len_m1,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       dp_a,
    output logic [7:0]       dp_b,
    output logic             dp_sub_sel,
    output logic             dp_csel,
    output logic             dp_addsub,
    output logic             dp_cmp_n,
    input  logic [7:0]       dp_sum,
    input  logic             dp_sign,
    input  logic             dp_z,
    output logic             busy,
    output logic             done,
    output logic             res_sign,
    output logic             res_zero,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLAG,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic             sub_q, sub_d;
    logic             cmp_q, cmp_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             zacc_q, zacc_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             done_q, done_d;
    logic             res_sign_q, res_sign_d;
    logic             res_zero_q, res_zero_d;
    logic             err_q, err_d;

    logic in_ready_w;
    logic accept;
    logic last;
    logic op_ok;
    logic unused_dp_z;

    // Zero detection is done on dp_sum directly; the datapath flag is redundant.
    assign unused_dp_z = dp_z;

`ifdef ADDSUB_SEQ_OPCHECK_EN
    assign op_ok = (op != 2'b11);
`else
    assign op_ok = 1'b1;
`endif

    // A compare never emits bytes, so it is never throttled by out_ready.
    assign in_ready_w = (state_q == RUN) & (~out_valid_q | out_ready | cmp_q);
    assign accept     = in_valid & in_ready_w;
    assign last       = (cnt_q == len_q);

    always_comb begin
        state_d     = state_q;
        sub_d       = sub_q;
        cmp_d       = cmp_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        zacc_d      = zacc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        res_sign_d  = res_sign_q;
        res_zero_d  = res_zero_q;
        err_d       = 1'b0;

        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start && op_ok) begin
                    state_d    = RUN;
                    sub_d      = (op != 2'b00);
                    cmp_d      = op[1];
                    len_d      = len_m1;
                    cnt_d      = '0;
                    zacc_d     = 1'b1;
                    res_sign_d = 1'b0;
                    res_zero_d = 1'b0;
                end else if (start) begin
                    err_d = 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    zacc_d = zacc_q & (dp_sum == 8'h00);
                    if (!cmp_q) begin
                        out_valid_d = 1'b1;
                        out_data_d  = dp_sum;
                    end
                    if (last) begin
                        state_d = FLAG;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            // Datapath flags settle during this cycle; sample them at its end.
            FLAG: begin
                state_d    = DONE;
                done_d     = 1'b1;
                res_sign_d = dp_sign;
                res_zero_d = zacc_q;
            end
            DONE: begin
                if (!out_valid_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sub_q       <= 1'b0;
            cmp_q       <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            zacc_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            done_q      <= 1'b0;
            res_sign_q  <= 1'b0;
            res_zero_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sub_q       <= sub_d;
            cmp_q       <= cmp_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            zacc_q      <= zacc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
            res_sign_q  <= res_sign_d;
            res_zero_q  <= res_zero_d;
            err_q       <= err_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign in_ready   = in_ready_w;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign res_sign   = res_sign_q;
    assign res_zero   = res_zero_q;
`ifdef ADDSUB_SEQ_OPCHECK_EN
    assign err        = err_q;
`else
    assign err        = 1'b0;
`endif

    assign dp_a       = in_a;
    assign dp_b       = in_b;
    assign dp_sub_sel = sub_q;
    // Byte 0 takes carry-in from sub_sel; later bytes chain the held carry.
    assign dp_csel    = (cnt_q == '0);
    assign dp_addsub  = accept;
    assign dp_cmp_n   = ~(accept & last);

endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq with a behavioural 8-bit datapath.
// Table-driven operations plus stall, reset and op=11 sequences.
module tb_addsub_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [2:0] len_m1 = 3'd0;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] dp_a, dp_b, dp_sum;
    logic       dp_sub_sel, dp_csel, dp_addsub, dp_cmp_n;
    logic       dp_sign, dp_z;
    logic       busy, done, res_sign, res_zero, err;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic rand_bp = 1'b0;
    logic or_hold = 1'b1;

    always #5 clk = ~clk;

    addsub_seq #(.MAX_BYTES(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .len_m1(len_m1),
        .in_a(in_a), .in_b(in_b), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .dp_a(dp_a), .dp_b(dp_b), .dp_sub_sel(dp_sub_sel), .dp_csel(dp_csel),
        .dp_addsub(dp_addsub), .dp_cmp_n(dp_cmp_n), .dp_sum(dp_sum),
        .dp_sign(dp_sign), .dp_z(dp_z), .busy(busy), .done(done),
        .res_sign(res_sign), .res_zero(res_zero), .err(err)
    );

    // Behavioural datapath: carry held unless dp_addsub, sign from last byte.
    logic       cy_q = 1'b0;
    logic       sg_q = 1'b0;
    logic       cin;
    logic [8:0] s9;
    always_comb begin
        cin = dp_csel ? dp_sub_sel : cy_q;
        s9  = {1'b0, dp_a} + {1'b0, (dp_sub_sel ? ~dp_b : dp_b)} + {8'h00, cin};
    end
    assign dp_sum  = s9[7:0];
    assign dp_z    = (s9[7:0] == 8'h00);
    assign dp_sign = sg_q;
    always @(posedge clk) begin
        if (dp_addsub) cy_q <= s9[8];
        if (dp_addsub && !dp_cmp_n) sg_q <= s9[7];
    end

    always begin
        @(posedge clk);
        #2;
        out_ready = rand_bp ? 1'($urandom_range(0, 1)) : or_hold;
    end

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {1'b1, out_data}, 9'h000);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  len;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
        logic        s;
        logic        z;
    } vec_t;

    vec_t tbl[8];

    task automatic do_start(input logic [1:0] o, input logic [2:0] l);
        start = 1'b1;
        op = o;
        len_m1 = l;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", busy, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] a, input logic [7:0] b,
                             input int i, input int n, input logic [1:0] o,
                             input logic [7:0] r);
        bit ok = 0;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            chk("in_ready_timeout", 1'b0, 1'b1);
        end else begin
            chk("dp_ctrl",
                {dp_addsub, dp_csel, dp_sub_sel, dp_cmp_n, dp_a, dp_b},
                {1'b1, i == 0, o != 2'b00, i != n - 1, a, b});
            if (o[1] == 1'b0) exp_q.push_back(r);
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic finish_op(input logic s, input logic z);
        bit ok = 0;
        bit extra = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
        end
        chk("done_seen", ok, 1'b1);
        chk("res_flags", {res_sign, res_zero, err}, {s, z, 1'b0});
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) extra = 1;
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        chk("done_once_idle", {extra, ok}, 2'b01);
        chk("sb_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_row(input vec_t v);
        int n;
        n = int'(v.len) + 1;
        do_start(v.op, v.len);
        for (int i = 0; i < n; i++) begin
            send_byte(v.a[8*i +: 8], v.b[8*i +: 8], i, n, v.op, v.r[8*i +: 8]);
        end
        finish_op(v.s, v.z);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 want 0");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0] = '{2'b00, 3'd1, 64'h01FF, 64'h0001, 64'h0200, 1'b0, 1'b0};
        tbl[1] = '{2'b01, 3'd0, 64'h05, 64'h05, 64'h00, 1'b0, 1'b1};
        tbl[2] = '{2'b10, 3'd1, 64'h0100, 64'h0200, 64'h0, 1'b1, 1'b0};
        tbl[3] = '{2'b00, 3'd2, 64'h00FFFF, 64'h000001, 64'h010000, 1'b0, 1'b0};
        tbl[4] = '{2'b01, 3'd3, 64'h1, 64'h2, 64'hFFFFFFFF, 1'b1, 1'b0};
        tbl[5] = '{2'b00, 3'd7, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h0, 1'b0, 1'b1};
        tbl[6] = '{2'b10, 3'd0, 64'h10, 64'h10, 64'h0, 1'b0, 1'b1};
        tbl[7] = '{2'b01, 3'd1, 64'h1234, 64'h0034, 64'h1200, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state",
            {busy, done, in_ready, out_valid, out_data, dp_addsub, dp_cmp_n,
             dp_csel, dp_sub_sel, res_sign, res_zero, err},
            {3'b000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000});
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int p = 0; p < 2; p++) begin
            rand_bp = (p == 1);
            for (int t = 0; t < 8; t++) run_row(tbl[t]);
        end
        rand_bp = 1'b0;
        or_hold = 1'b1;
        @(posedge clk);
        #1;

        // Stall after byte 0 of a 3-byte ADD; a stray start is ignored.
        or_hold = 1'b0;
        @(posedge clk);
        #1;
        do_start(2'b00, 3'd2);
        send_byte(8'hFF, 8'h01, 0, 3, 2'b00, 8'h00);
        in_a = 8'h01;
        in_b = 8'h00;
        in_valid = 1'b1;
        start = 1'b1;
        op = 2'b01;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall", {in_ready, dp_addsub, out_valid}, 3'b001);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        or_hold = 1'b1;
        send_byte(8'h01, 8'h00, 1, 3, 2'b00, 8'h02);
        send_byte(8'h01, 8'h00, 2, 3, 2'b00, 8'h01);
        finish_op(1'b0, 1'b0);

        // Reset after byte 1 of a 4-byte SUB.
        do_start(2'b01, 3'd3);
        send_byte(8'h10, 8'h01, 0, 4, 2'b01, 8'h0F);
        send_byte(8'h20, 8'h02, 1, 4, 2'b01, 8'h1E);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_reset",
            {busy, in_ready, out_valid, out_data, dp_addsub, res_sign, res_zero},
            {3'b000, 8'h00, 1'b0, 2'b00});
        exp_q.delete();
        @(posedge clk);
        #1;
        do_start(2'b00, 3'd0);
        send_byte(8'h7F, 8'h01, 0, 1, 2'b00, 8'h80);
        finish_op(1'b1, 1'b0);

        // op = 11
`ifdef ADDSUB_SEQ_OPCHECK_EN
        start = 1'b1;
        op = 2'b11;
        len_m1 = 3'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("op3_err", {err, busy}, 2'b10);
        @(negedge clk);
        chk("op3_err_end", {err, busy}, 2'b00);
        @(posedge clk);
        #1;
`else
        run_row('{2'b11, 3'd0, 64'h01, 64'h02, 64'h0, 1'b1, 1'b0});
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_seq.md
ADDSUB_SEQ -- requirements
Module: addsub_seq

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 8, maximum operand length in bytes (power of two, 2..256).
REQ-002 SHALL have parameter LEN_W, default $clog2(MAX_BYTES), width of the len_m1 field.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  command strobe, sampled in IDLE only.
REQ-006 SHALL have port op  input  2  00=ADD, 01=SUB, 10=CMP (11 see REQ-028).
REQ-007 SHALL have port len_m1  input  LEN_W  operand length minus one, in bytes.
REQ-008 SHALL have ports in_a, in_b  input  8 each  operand bytes, least significant first.
REQ-009 SHALL have ports in_valid input 1, in_ready output 1  operand byte handshake.
REQ-010 SHALL have ports out_data output 8, out_valid output 1, out_ready input 1  result byte stream.
REQ-011 SHALL have ports dp_a, dp_b output 8, dp_sub_sel, dp_csel, dp_addsub, dp_cmp_n output 1  adder/subtractor datapath controls.
REQ-012 SHALL have ports dp_sum input 8, dp_sign input 1, dp_z input 1  datapath results.
REQ-013 SHALL have ports busy, done output 1, res_sign, res_zero output 1, err output 1.

Function
REQ-014 SHALL implement states IDLE, RUN, FLAG, DONE.
REQ-015 IDLE: start=1 with legal op -> capture op and len_m1, clear byte counter and zero accumulator, go to RUN; busy=1 from the next cycle.
REQ-016 RUN: in_ready = !out_valid | out_ready | (op==CMP); a byte is accepted when in_valid & in_ready.
REQ-017 On accept: dp_a=in_a and dp_b=in_b in the same cycle (combinational); dp_sub_sel=(op!=ADD); dp_csel=1 on byte 0 (carry-in = sub_sel) and 0 otherwise (chained carry); dp_addsub=1.
REQ-018 Cycles without accept SHALL drive dp_addsub=0 so the datapath carry is held across stalls.
REQ-019 dp_cmp_n SHALL be 0 only in the accept cycle of byte len_m1, and 1 otherwise.
REQ-020 ADD/SUB: dp_sum SHALL be registered into out_data with out_valid=1 on the edge after accept; out_valid is held until out_ready.
REQ-021 CMP: no bytes are emitted; out_valid stays 0.
REQ-022 Zero accumulator: zacc &= (dp_sum==8'h00) on every accept.
REQ-023 After the last accept, go to FLAG for one cycle (datapath flags settle on the falling edge), then DONE.
REQ-024 DONE: done=1 for exactly one cycle; res_sign=dp_sign and res_zero=zacc are latched and held until the next start; return to IDLE only once out_valid=0.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 len_m1=0 SHALL perform a single-byte operation with csel=1 and cmp_n=0 on the same byte.

Reset
REQ-027 rst=1 at any edge, including mid-operation, SHALL force: state=IDLE, busy=0, done=0, in_ready=0, out_valid=0, out_data=0, dp_addsub=0, dp_cmp_n=1, dp_csel=1, dp_sub_sel=0, res_sign=0, res_zero=0, err=0, byte counter=0; a partially emitted result is discarded.

Configuration
REQ-028 Macro ADDSUB_SEQ_OPCHECK_EN: when defined, start with op=11 in IDLE SHALL pulse err=1 for one cycle and remain in IDLE; when undefined, op=11 SHALL be executed as CMP and err SHALL be tied to 0.

Verification
REQ-029 ADD with len_m1=1, A=0x01FF, B=0x0001 -> out bytes 0x00 then 0x02; done; res_zero=0.
REQ-030 SUB with len_m1=0, A=0x05, B=0x05 -> out byte 0x00; res_zero=1, res_sign=0; dp_csel=1 and dp_sub_sel=1 on the accept cycle.
REQ-031 CMP with len_m1=1, A=0x0100, B=0x0200 -> no out_valid; res_sign=1, res_zero=0; done exactly once.
REQ-032 ADD with 3 bytes, out_ready held 0 for 5 cycles after byte 0 -> in_ready=0 and dp_addsub=0 during the stall; final bytes correct with the carry preserved.
REQ-033 rst pulsed after byte 1 of a 4-byte SUB -> next cycle: IDLE, out_valid=0, busy=0; a following ADD 0x7F+0x01 -> 0x80.
REQ-034 With ADDSUB_SEQ_OPCHECK_EN defined, start with op=11 -> err=1 for one cycle, busy stays 0; without the macro -> CMP behaviour, err=0.
